// File: rtl/ex_stage_pkg.sv
// Shared pipeline definitions: default field widths, the opcode flag bundle
// and the occupancy encoding of the two-entry stage buffer.
package ex_stage_pkg;

  localparam int unsigned IMMEDIATE_WIDTH_DEF   = 16;
  localparam int unsigned DATA_WIDTH_DEF        = 64;
  localparam int unsigned REG_INDEX_BITS_DEF    = 5;
  localparam int unsigned THREAD_INDEX_BITS_DEF = 3;

  typedef struct packed {
    logic increment;
    logic load_word;
    logic store_word;
  } op_flags_t;

  localparam int unsigned FLAGS_WIDTH = $bits(op_flags_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute-to-memory bundle: upstream instruction, write-back bypass,
// thread flush and the downstream result, each with its valid/ready pair.
interface ex_stage_if
  import ex_stage_pkg::*;
#(
  parameter int unsigned IMMEDIATE_WIDTH   = IMMEDIATE_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned REG_INDEX_BITS    = REG_INDEX_BITS_DEF,
  parameter int unsigned THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF
);

  logic                         in_valid;
  logic                         out_ready;
  logic                         in_increment_flag;
  logic                         in_load_word_flag;
  logic                         in_store_word_flag;
  logic [IMMEDIATE_WIDTH-1:0]   in_immediate;
  logic [THREAD_INDEX_BITS-1:0] in_thread_index;
  logic [REG_INDEX_BITS-1:0]    in_reg_index;
  logic [DATA_WIDTH-1:0]        in_data;

  logic                         in_wb_valid;
  logic [THREAD_INDEX_BITS-1:0] in_wb_thread_index;
  logic [REG_INDEX_BITS-1:0]    in_wb_reg_index;
  logic [DATA_WIDTH-1:0]        in_wb_data;

  logic                         in_flush;
  logic [THREAD_INDEX_BITS-1:0] in_flush_thread;

  logic                         out_valid;
  logic                         in_ready;
  logic                         out_increment_flag;
  logic                         out_load_word_flag;
  logic                         out_store_word_flag;
  logic [IMMEDIATE_WIDTH-1:0]   out_immediate;
  logic [THREAD_INDEX_BITS-1:0] out_thread_index;
  logic [REG_INDEX_BITS-1:0]    out_reg_index;
  logic [DATA_WIDTH-1:0]        out_data;

  modport slave (
    input  in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
           in_immediate, in_thread_index, in_reg_index, in_data,
           in_wb_valid, in_wb_thread_index, in_wb_reg_index, in_wb_data,
           in_flush, in_flush_thread, in_ready,
    output out_ready, out_valid, out_increment_flag, out_load_word_flag,
           out_store_word_flag, out_immediate, out_thread_index, out_reg_index,
           out_data
  );

  modport master (
    output in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
           in_immediate, in_thread_index, in_reg_index, in_data,
           in_wb_valid, in_wb_thread_index, in_wb_reg_index, in_wb_data,
           in_flush, in_flush_thread, in_ready,
    input  out_ready, out_valid, out_increment_flag, out_load_word_flag,
           out_store_word_flag, out_immediate, out_thread_index, out_reg_index,
           out_data
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry in-order buffer (main + skid) with a registered ready and
// per-thread invalidation; outputs come from the main entry only.
module skid_buffer
  import ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned THREAD_LSB  = 0,
  parameter int unsigned THREAD_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  input  logic                   flush_i,
  input  logic [THREAD_BITS-1:0] flush_thread_i
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;

  logic main_v, skid_v;
  logic in_hit, main_hit, skid_hit;
  logic push, pop, main_keep, skid_keep;

  assign main_v = (state_q != BUF_EMPTY);
  assign skid_v = (state_q == BUF_FULL);

  assign in_hit   = flush_i && (in_data_i[THREAD_LSB +: THREAD_BITS] == flush_thread_i);
  assign main_hit = flush_i && (main_q[THREAD_LSB +: THREAD_BITS] == flush_thread_i);
  assign skid_hit = flush_i && (skid_q[THREAD_LSB +: THREAD_BITS] == flush_thread_i);

  // A popped entry leaves regardless of a flush hit, so the hit only matters
  // for an entry that would otherwise stay.
  assign push      = in_valid_i && ready_q && !in_hit;
  assign pop       = main_v && out_ready_i;
  assign main_keep = main_v && !pop && !main_hit;
  assign skid_keep = skid_v && !skid_hit;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (main_keep) begin
      if (skid_keep) begin
        state_d = BUF_FULL;
      end else if (push) begin
        skid_d  = in_data_i;
        state_d = BUF_FULL;
      end else begin
        state_d = BUF_ONE;
      end
    end else if (skid_keep) begin
      // Skid is only valid while ready is low, so no push can coincide here.
      main_d  = skid_q;
      state_d = BUF_ONE;
    end else if (push) begin
      main_d  = in_data_i;
      state_d = BUF_ONE;
    end else begin
      state_d = BUF_EMPTY;
    end
    ready_d = (state_d != BUF_FULL);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values. The payload registers are reset too, because the
  // outputs must read zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_v;
  assign out_data_o  = main_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: write-back bypass on the operand, optional increment, then a
// two-entry skid buffer toward the memory stage with per-thread flush.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned IMMEDIATE_WIDTH   = IMMEDIATE_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned REG_INDEX_BITS    = REG_INDEX_BITS_DEF,
  parameter int unsigned THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF
) (
  input logic        clk,
  input logic        rst_n,
  ex_stage_if.slave  bus
);

  localparam int unsigned PAYLOAD_WIDTH = FLAGS_WIDTH + IMMEDIATE_WIDTH +
                                          THREAD_INDEX_BITS + REG_INDEX_BITS + DATA_WIDTH;
  localparam int unsigned THREAD_LSB    = REG_INDEX_BITS + DATA_WIDTH;

  op_flags_t                in_flags, out_flags;
  logic                     bypass_hit;
  logic [DATA_WIDTH-1:0]    operand, result;
  logic [PAYLOAD_WIDTH-1:0] in_payload, out_payload;

  assign in_flags = op_flags_t'{bus.in_increment_flag, bus.in_load_word_flag,
                                bus.in_store_word_flag};

  // The bypass is sampled only on the capture cycle; later write-backs do not
  // touch an instruction already held here.
  assign bypass_hit = bus.in_wb_valid &&
                      (bus.in_wb_thread_index == bus.in_thread_index) &&
                      (bus.in_wb_reg_index == bus.in_reg_index);
  assign operand    = bypass_hit ? bus.in_wb_data : bus.in_data;
  assign result     = in_flags.increment ? operand + DATA_WIDTH'(1) : operand;

  assign in_payload = {in_flags, bus.in_immediate, bus.in_thread_index,
                       bus.in_reg_index, result};

  skid_buffer #(
    .WIDTH       (PAYLOAD_WIDTH),
    .THREAD_LSB  (THREAD_LSB),
    .THREAD_BITS (THREAD_INDEX_BITS)
  ) u_skid_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (bus.in_valid),
    .in_ready_o     (bus.out_ready),
    .in_data_i      (in_payload),
    .out_valid_o    (bus.out_valid),
    .out_ready_i    (bus.in_ready),
    .out_data_o     (out_payload),
    .flush_i        (bus.in_flush),
    .flush_thread_i (bus.in_flush_thread)
  );

  assign {out_flags, bus.out_immediate, bus.out_thread_index,
          bus.out_reg_index, bus.out_data} = out_payload;

  assign bus.out_increment_flag  = out_flags.increment;
  assign bus.out_load_word_flag  = out_flags.load_word;
  assign bus.out_store_word_flag = out_flags.store_word;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes expected results on each
// accepted instruction, the monitor checks every cycle and pops on transfer.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          inc;
    bit          lw;
    bit          sw;
    logic [15:0] imm;
    logic [2:0]  thr;
    logic [4:0]  rg;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   up_ready = 1'b1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the instruction as it should appear downstream, computed from
  // the inputs on the cycle it is accepted.
  function automatic exp_t model_capture();
    exp_t        e;
    logic [63:0] operand;
    if (bus.in_wb_valid && bus.in_wb_thread_index == bus.in_thread_index &&
        bus.in_wb_reg_index == bus.in_reg_index)
      operand = bus.in_wb_data;
    else
      operand = bus.in_data;
    e.inc  = bus.in_increment_flag;
    e.lw   = bus.in_load_word_flag;
    e.sw   = bus.in_store_word_flag;
    e.imm  = bus.in_immediate;
    e.thr  = bus.in_thread_index;
    e.rg   = bus.in_reg_index;
    e.data = bus.in_increment_flag ? operand + 64'd1 : operand;
    return e;
  endfunction

  // Monitor: compares the DUT against the oldest held entry, then applies the
  // coming edge's downstream transfer and flush to the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("out_ready", bus.out_ready, sb.size() < 2);
      if (sb.size() != 0) begin
        check("out_data",       bus.out_data,            sb[0].data);
        check("out_thread",     bus.out_thread_index,    sb[0].thr);
        check("out_reg",        bus.out_reg_index,       sb[0].rg);
        check("out_immediate",  bus.out_immediate,       sb[0].imm);
        check("out_inc_flag",   bus.out_increment_flag,  sb[0].inc);
        check("out_lw_flag",    bus.out_load_word_flag,  sb[0].lw);
        check("out_sw_flag",    bus.out_store_word_flag, sb[0].sw);
      end
      up_ready = (sb.size() < 2);
      if (sb.size() != 0 && bus.in_ready) void'(sb.pop_front());
      if (bus.in_flush) begin
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].thr == bus.in_flush_thread) sb.delete(i);
      end
    end
  end

  // One clock: entered and left at posedge+1; records the expected result if
  // the current instruction is accepted at the coming edge.
  task automatic step(output bit acc);
    @(negedge clk);
    #1;
    acc = bus.in_valid && up_ready;
    if (acc && !(bus.in_flush && bus.in_flush_thread == bus.in_thread_index))
      sb.push_back(model_capture());
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit inc, logic [2:0] thr, logic [4:0] rg, logic [63:0] d);
    bus.in_valid           = 1'b1;
    bus.in_increment_flag  = inc;
    bus.in_load_word_flag  = thr[0];
    bus.in_store_word_flag = thr[1];
    bus.in_immediate       = 16'hA500 | 16'(rg);
    bus.in_thread_index    = thr;
    bus.in_reg_index       = rg;
    bus.in_data            = d;
  endtask

  task automatic drain();
    bit acc;
    bus.in_valid    = 1'b0;
    bus.in_ready    = 1'b1;
    bus.in_flush    = 1'b0;
    bus.in_wb_valid = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step(acc);
    step(acc);
    check("drain_out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bit pending;

    bus.in_valid = 0; bus.in_increment_flag = 0; bus.in_load_word_flag = 0;
    bus.in_store_word_flag = 0; bus.in_immediate = '0; bus.in_thread_index = '0;
    bus.in_reg_index = '0; bus.in_data = '0; bus.in_wb_valid = 0;
    bus.in_wb_thread_index = '0; bus.in_wb_reg_index = '0; bus.in_wb_data = '0;
    bus.in_flush = 0; bus.in_flush_thread = '0; bus.in_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",  bus.out_valid,          1'b0);
    check("rst_out_ready",  bus.out_ready,          1'b1);
    check("rst_out_data",   bus.out_data,           64'h0);
    check("rst_out_thread", bus.out_thread_index,   3'd0);
    check("rst_out_flags",  {bus.out_increment_flag, bus.out_load_word_flag,
                             bus.out_store_word_flag}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain increment, then wrap-around at the all-ones operand.
    drive(1'b1, 3'd0, 5'd1, 64'h0000_0000_0000_0041);
    step(acc);
    bus.in_valid = 1'b0;
    check("inc_41_valid", bus.out_valid, 1'b1);
    check("inc_41_data",  bus.out_data,  64'h42);
    drive(1'b1, 3'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    step(acc);
    bus.in_valid = 1'b0;
    check("inc_wrap_data", bus.out_data, 64'h0);
    check("inc_wrap_reg",  bus.out_reg_index, 5'd2);
    drain();

    // Bypass hit, then a miss on thread index only.
    bus.in_wb_valid = 1'b1; bus.in_wb_thread_index = 3'd3;
    bus.in_wb_reg_index = 5'd7; bus.in_wb_data = 64'h10;
    drive(1'b1, 3'd3, 5'd7, 64'h99);
    step(acc);
    check("bypass_hit_data", bus.out_data, 64'h11);
    bus.in_wb_thread_index = 3'd2;
    step(acc);
    bus.in_valid = 1'b0;
    check("bypass_miss_data", bus.out_data, 64'h9A);
    drain();

    // Downstream stall with back-to-back A, B, C; C must wait upstream.
    bus.in_ready = 1'b0;
    drive(1'b0, 3'd0, 5'd10, 64'hA);
    step(acc);
    drive(1'b0, 3'd1, 5'd11, 64'hB);
    step(acc);
    check("stall_ready_low", bus.out_ready, 1'b0);
    drive(1'b0, 3'd2, 5'd12, 64'hC);
    step(acc);
    check("stall_main_is_a", bus.out_data, 64'hA);
    bus.in_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(acc);
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    drain();

    // Flush the main entry while stalled: skid moves up, ready returns.
    bus.in_ready = 1'b0;
    drive(1'b0, 3'd1, 5'd3, 64'h111);
    step(acc);
    drive(1'b0, 3'd4, 5'd4, 64'h444);
    step(acc);
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b1; bus.in_flush_thread = 3'd1;
    step(acc);
    bus.in_flush = 1'b0;
    check("flush_valid",       bus.out_valid,        1'b1);
    check("flush_main_thread", bus.out_thread_index, 3'd4);
    check("flush_ready",       bus.out_ready,        1'b1);
    drain();

    // Asynchronous reset while full: everything disappears at once.
    bus.in_ready = 1'b0;
    drive(1'b1, 3'd2, 5'd5, 64'h55);
    step(acc);
    drive(1'b1, 3'd5, 5'd6, 64'h66);
    step(acc);
    bus.in_valid = 1'b0;
    check("pre_reset_full", bus.out_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_ready", bus.out_ready, 1'b1);
    check("async_rst_data",  bus.out_data,  64'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_ready = 1'b1;
    repeat (3) step(acc);

    // Random traffic: holds each instruction until accepted, mixes in
    // bypass, flushes and downstream back-pressure.
    pending = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                            : {$urandom, $urandom});
          bus.in_load_word_flag  = 1'($urandom_range(0, 1));
          bus.in_store_word_flag = 1'($urandom_range(0, 1));
          bus.in_immediate       = 16'($urandom);
          pending = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.in_wb_valid        = 1'($urandom_range(0, 1));
      bus.in_wb_thread_index = ($urandom_range(0, 1) != 0) ? bus.in_thread_index
                                                           : 3'($urandom_range(0, 3));
      bus.in_wb_reg_index    = ($urandom_range(0, 1) != 0) ? bus.in_reg_index
                                                           : 5'($urandom_range(0, 3));
      bus.in_wb_data         = {$urandom, $urandom};
      bus.in_flush           = ($urandom_range(0, 7) == 0);
      bus.in_flush_thread    = 3'($urandom_range(0, 3));
      bus.in_ready           = ($urandom_range(0, 9) < 6);
      step(acc);
      if (acc) pending = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
